// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the pipe_skid_reg pipeline stage: occupancy state encoding
// and the default statistics counter width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int STATS_W_DEF = 16;

endpackage

// File: rtl/pipe_skid_reg_sat_cnt.sv
// Saturating up-counter with synchronous clear; it holds at all-ones
// rather than wrapping.
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + ONE_W;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a one-entry skid buffer.
// The optional stall/transfer statistics counters are built when PIPE_STATS_EN is defined.
//
//   state | meaning
//   EMPTY | no entry held, out_valid=0, out_data=BUBBLE
//   ONE   | main register valid, skid free
//   FULL  | main and skid valid, upstream held off
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = '0
`ifdef PIPE_STATS_EN
  ,parameter int               STATS_W = STATS_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
`ifdef PIPE_STATS_EN
  ,output logic [STATS_W-1:0] stall_cnt
  ,output logic [STATS_W-1:0] xfer_cnt
`endif
);

  state_t            r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_in_ready;
  logic              r_out_valid;

  logic w_in_fire;
  logic w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // The rst_n pin is active-high; flush sits below reset and above the handshakes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= EMPTY;
      r_main      <= BUBBLE;
      r_skid      <= BUBBLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_main      <= BUBBLE;
      r_skid      <= BUBBLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_main      <= in_data;
            r_state     <= ONE;
            r_out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= in_data;
          end else if (w_in_fire) begin
            r_skid     <= in_data;
            r_state    <= FULL;
            r_in_ready <= 1'b0;
          end else if (w_out_fire) begin
            // Returning to BUBBLE keeps out_data clean whenever out_valid is low.
            r_main      <= BUBBLE;
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            r_main     <= r_skid;
            r_skid     <= BUBBLE;
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_main      <= BUBBLE;
          r_skid      <= BUBBLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;

`ifdef PIPE_STATS_EN
  logic w_stall_inc;

  assign w_stall_inc = r_out_valid & ~out_ready;

  // Counters clear on reset only; flush leaves them running.
  pipe_sat_cnt #(.W(STATS_W)) u_stall_cnt (
    .clk   (clk),
    .i_clr (rst_n),
    .i_inc (w_stall_inc),
    .o_cnt (stall_cnt)
  );

  pipe_sat_cnt #(.W(STATS_W)) u_xfer_cnt (
    .clk   (clk),
    .i_clr (rst_n),
    .i_inc (w_out_fire),
    .o_cnt (xfer_cnt)
  );
`endif

endmodule
